// File: rtl/jk_bank_arbiter.sv
// Bank of WIDTH JK cells shared between two requesters with round-robin
// arbitration. Commands are latched at grant, applied, then acknowledged.
//
// state | meaning
// IDLE  | no owner; sample requests and grant the winner
// APPLY | winner owns bank; latched JK command is written into q at edge
// ACK   | updated q visible; winner's ack pulses for this single cycle
module jk_bank_arbiter #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [1:0]       jk0,
  input  logic [WIDTH-1:0] mask0,
  input  logic             req1,
  input  logic [1:0]       jk1,
  input  logic [WIDTH-1:0] mask1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             ack0,
  output logic             ack1,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             busy,
  output logic [CNT_W-1:0] ops_cnt
);

  typedef enum logic [1:0] {IDLE, APPLY, ACK} state_t;

  state_t           state;
  logic [1:0]       cmd_jk;
  logic [WIDTH-1:0] cmd_mask;
  logic             win;
  logic             rr;
  logic             pick1;
  logic [WIDTH-1:0] q_next;

  // rr=0 prefers requester 0; a lone request always wins
  assign pick1 = req1 & (~req0 | rr);
  assign qb    = ~q;

  always_comb begin
    q_next = q;
    for (int i = 0; i < WIDTH; i++) begin
      if (cmd_mask[i]) begin
        case (cmd_jk)
          2'b01:   q_next[i] = 1'b0;
          2'b10:   q_next[i] = 1'b1;
          2'b11:   q_next[i] = ~q[i];
          default: q_next[i] = q[i];
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      q        <= '0;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      busy     <= 1'b0;
      ops_cnt  <= '0;
      rr       <= 1'b0;
      win      <= 1'b0;
      cmd_jk   <= 2'b00;
      cmd_mask <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 | req1) begin
            win      <= pick1;
            cmd_jk   <= pick1 ? jk1 : jk0;
            cmd_mask <= pick1 ? mask1 : mask0;
            gnt0     <= ~pick1;
            gnt1     <= pick1;
            busy     <= 1'b1;
            state    <= APPLY;
          end
        end
        APPLY: begin
          q     <= q_next;
          ack0  <= ~win;
          ack1  <= win;
          state <= ACK;
        end
        ACK: begin
          gnt0    <= 1'b0;
          gnt1    <= 1'b0;
          ack0    <= 1'b0;
          ack1    <= 1'b0;
          busy    <= 1'b0;
          ops_cnt <= ops_cnt + CNT_W'(1);
          rr      <= ~win;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
